// File: rtl/touch_spi_funcmod.sv
// touch_spi_funcmod
//   SPI function stage for a resistive-touch ADC (XPT2046-class). A read call
//   runs one 24-SCLK conversion frame (8 command bits, one busy clock, 8 result
//   bits, 7 trailing clocks). The 8-bit result is returned with a one-cycle
//   done pulse.
//
// Ports
//   CLOCK    in   system clock, rising edge
//   RESET    in   asynchronous active-high reset
//   iCall    in   [1] read X, [0] read Y (X wins); held by caller until oDone
//   oDone    out  one-cycle pulse, oData valid
//   oData    out  last conversion result, held until next oDone
//   TP_CS_N  out  ADC chip select, active low
//   TP_CLK   out  SCLK, idles low (mode 0)
//   TP_DI    out  MOSI to ADC
//   TP_DO    in   MISO from ADC
module touch_spi_funcmod #(
    parameter int unsigned CLK_DIV = 25,
    parameter logic [7:0]  CMD_X   = 8'h98,
    parameter logic [7:0]  CMD_Y   = 8'hD8
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [1:0] iCall,
    output logic       oDone,
    output logic [7:0] oData,
    output logic       TP_CS_N,
    output logic       TP_CLK,
    output logic       TP_DI,
    input  logic       TP_DO
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCsSetup,
        StShift,
        StCsHold,
        StDone,
        StRelease
    } state_e;

    state_e           state;
    logic [DIV_W-1:0] div;
    logic [4:0]       bit_cnt;   // 0-based SCLK period index, 0..23
    logic [7:0]       tx;        // command shift register, MSB is on TP_DI
    logic [7:0]       rx;        // result shift register

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state   <= StIdle;
            div     <= '0;
            bit_cnt <= '0;
            tx      <= '0;
            rx      <= '0;
            TP_CS_N <= 1'b1;
            TP_CLK  <= 1'b0;
            TP_DI   <= 1'b0;
            oDone   <= 1'b0;
            oData   <= 8'h00;
        end else begin
            oDone <= 1'b0;
            unique case (state)
                StIdle: begin
                    div     <= '0;
                    bit_cnt <= '0;
                    TP_CLK  <= 1'b0;
                    if (iCall[1]) begin
                        tx      <= CMD_X;
                        TP_DI   <= CMD_X[7];
                        TP_CS_N <= 1'b0;
                        state   <= StCsSetup;
                    end else if (iCall[0]) begin
                        tx      <= CMD_Y;
                        TP_DI   <= CMD_Y[7];
                        TP_CS_N <= 1'b0;
                        state   <= StCsSetup;
                    end
                end

                StCsSetup: begin
                    if (div == DIV_LAST) begin
                        div   <= '0;
                        state <= StShift;
                    end else begin
                        div <= div + 1'b1;
                    end
                end

                StShift: begin
                    if (div != DIV_LAST) begin
                        div <= div + 1'b1;
                    end else begin
                        div <= '0;
                        if (!TP_CLK) begin
                            // Rising edge: sample MISO. Periods 10..17 carry the result.
                            TP_CLK <= 1'b1;
                            if (bit_cnt >= 5'd9 && bit_cnt <= 5'd16) begin
                                rx <= {rx[6:0], TP_DO};
                            end
                        end else begin
                            // Falling edge: advance MOSI; tx drains to zero after 8 bits.
                            TP_CLK <= 1'b0;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt <= '0;
                                TP_DI   <= 1'b0;
                                state   <= StCsHold;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                                tx      <= {tx[6:0], 1'b0};
                                TP_DI   <= tx[6];
                            end
                        end
                    end
                end

                StCsHold: begin
                    if (div == DIV_LAST) begin
                        div     <= '0;
                        TP_CS_N <= 1'b1;
                        oDone   <= 1'b1;
                        oData   <= rx;
                        state   <= StDone;
                    end else begin
                        div <= div + 1'b1;
                    end
                end

                StDone: begin
                    state <= StRelease;
                end

                // One dead cycle so a caller still holding its call bit cannot retrigger.
                StRelease: begin
                    state <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_touch_spi_funcmod.sv
// Testbench for touch_spi_funcmod: two instances (CLK_DIV=25 and CLK_DIV=2),
// each with a behavioural ADC model that captures the command byte and
// returns a programmed result on periods 10..17.
module tb_touch_spi_funcmod;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- instance A (CLK_DIV = 25) ----------------
    logic [1:0] call_a = 2'b00;
    logic       done_a, cs_a, sclk_a, di_a;
    logic       do_a = 1'b0;
    logic [7:0] data_a;

    touch_spi_funcmod #(.CLK_DIV(25)) dut_a (
        .CLOCK   (clk),
        .RESET   (rst),
        .iCall   (call_a),
        .oDone   (done_a),
        .oData   (data_a),
        .TP_CS_N (cs_a),
        .TP_CLK  (sclk_a),
        .TP_DI   (di_a),
        .TP_DO   (do_a)
    );

    // ---------------- instance B (CLK_DIV = 2) -----------------
    logic [1:0] call_b = 2'b00;
    logic       done_b, cs_b, sclk_b, di_b;
    logic       do_b = 1'b0;
    logic [7:0] data_b;

    touch_spi_funcmod #(.CLK_DIV(2)) dut_b (
        .CLOCK   (clk),
        .RESET   (rst),
        .iCall   (call_b),
        .oDone   (done_b),
        .oData   (data_b),
        .TP_CS_N (cs_b),
        .TP_CLK  (sclk_b),
        .TP_DI   (di_b),
        .TP_DO   (do_b)
    );

    // ---------------- ADC model A with SCLK width checking -----
    logic       sclk_qa = 1'b0, cs_qa = 1'b1, width_bad_a = 1'b0;
    int         rise_a = 0, fall_a = 0, hi_a = 0, per_a = 0;
    logic [7:0] rx_cmd_a = 8'h00, adc_a = 8'h00;

    always @(posedge clk) begin
        sclk_qa <= sclk_a;
        cs_qa   <= cs_a;
        if (cs_qa && !cs_a) begin
            rise_a <= 0; fall_a <= 0; hi_a <= 0; per_a <= 0;
            width_bad_a <= 1'b0; do_a <= 1'b0;
        end else if (!cs_a) begin
            per_a <= per_a + 1;
            if (sclk_a) hi_a <= hi_a + 1;
            if (sclk_a && !sclk_qa) begin
                rise_a <= rise_a + 1;
                if (rise_a < 8) rx_cmd_a <= {rx_cmd_a[6:0], di_a};
                if (rise_a > 0 && per_a != 50) width_bad_a <= 1'b1;
                per_a <= 1;
            end
            if (!sclk_a && sclk_qa) begin
                fall_a <= fall_a + 1;
                do_a   <= (fall_a >= 8 && fall_a <= 15) ? adc_a[15-fall_a] : 1'b0;
                if (hi_a != 25) width_bad_a <= 1'b1;
                hi_a <= 0;
            end
        end
    end

    // ---------------- ADC model B ------------------------------
    logic       sclk_qb = 1'b0, cs_qb = 1'b1;
    int         rise_b = 0, fall_b = 0;
    logic [7:0] rx_cmd_b = 8'h00, adc_b = 8'h00;

    always @(posedge clk) begin
        sclk_qb <= sclk_b;
        cs_qb   <= cs_b;
        if (cs_qb && !cs_b) begin
            rise_b <= 0; fall_b <= 0; do_b <= 1'b0;
        end else if (!cs_b) begin
            if (sclk_b && !sclk_qb) begin
                rise_b <= rise_b + 1;
                if (rise_b < 8) rx_cmd_b <= {rx_cmd_b[6:0], di_b};
            end
            if (!sclk_b && sclk_qb) begin
                fall_b <= fall_b + 1;
                do_b   <= (fall_b >= 8 && fall_b <= 15) ? adc_b[15-fall_b] : 1'b0;
            end
        end
    end

    // ---------------- event monitors (instance A) --------------
    int          done_cnt_a = 0, cs_fall_cnt_a = 0;
    int unsigned cs_fall_cyc_a = 0;
    logic        cs_na = 1'b1;

    always @(negedge clk) begin
        cs_na <= cs_a;
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (cs_na && !cs_a) begin
            cs_fall_cnt_a <= cs_fall_cnt_a + 1;
            cs_fall_cyc_a <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits at negedges until the selected oDone is high, bounded by limit.
    task automatic wait_done(input bit inst_b, input string tag, input int limit);
        int n;
        n = 0;
        while (!(inst_b ? done_b : done_a) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({tag, " done seen"}, {31'd0, (inst_b ? done_b : done_a)}, 32'd1);
    endtask

    int unsigned t0;
    int          d0, f0, n;

    initial begin
        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst cs_n", {31'd0, cs_a}, 32'd1);
        check("rst sclk", {31'd0, sclk_a}, 32'd0);
        check("rst di", {31'd0, di_a}, 32'd0);
        check("rst done", {31'd0, done_a}, 32'd0);
        check("rst data", {24'd0, data_a}, 32'h00);
        check("rst cs_n b", {31'd0, cs_b}, 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ---- 1: X read, A5, latency ----
        adc_a = 8'hA5;
        @(posedge clk); #1 call_a = 2'b10; t0 = cyc;
        wait_done(1'b0, "t1", 3000);
        check("t1 latency", cyc - t0, 32'd1251);
        check("t1 data", {24'd0, data_a}, 32'hA5);
        check("t1 cmd", {24'd0, rx_cmd_a}, 32'h98);
        call_a = 2'b00;
        @(negedge clk);
        check("t1 done width", {31'd0, done_a}, 32'd0);
        check("t1 cs fall", cs_fall_cyc_a - t0, 32'd1);
        repeat (4) @(negedge clk);

        // ---- 2: Y read, 3C, SCLK shape ----
        adc_a = 8'h3C;
        @(posedge clk); #1 call_a = 2'b01;
        wait_done(1'b0, "t2", 3000);
        check("t2 data", {24'd0, data_a}, 32'h3C);
        check("t2 cmd", {24'd0, rx_cmd_a}, 32'hD8);
        check("t2 pulses", rise_a, 32'd24);
        check("t2 width ok", {31'd0, width_bad_a}, 32'd0);
        call_a = 2'b00;
        repeat (4) @(negedge clk);

        // ---- 3: both bits -> X first, then Y ----
        d0 = done_cnt_a; f0 = cs_fall_cnt_a;
        adc_a = 8'h5A;
        @(posedge clk); #1 call_a = 2'b11;
        wait_done(1'b0, "t3x", 3000);
        check("t3 x cmd", {24'd0, rx_cmd_a}, 32'h98);
        check("t3 x data", {24'd0, data_a}, 32'h5A);
        call_a = 2'b01;
        adc_a  = 8'hC3;
        @(negedge clk);
        wait_done(1'b0, "t3y", 3000);
        check("t3 y cmd", {24'd0, rx_cmd_a}, 32'hD8);
        check("t3 y data", {24'd0, data_a}, 32'hC3);
        call_a = 2'b00;
        repeat (1400) @(negedge clk);
        check("t3 done count", done_cnt_a - d0, 32'd2);
        check("t3 frame count", cs_fall_cnt_a - f0, 32'd2);

        // ---- 4: reset mid-frame ----
        adc_a = 8'h77;
        @(posedge clk); #1 call_a = 2'b10;
        n = 0;
        while (rise_a < 12 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t4 reached p12", {31'd0, rise_a >= 12}, 32'd1);
        repeat (5) @(negedge clk);
        d0 = done_cnt_a;
        rst = 1'b1;
        #1;
        check("t4 cs_n async", {31'd0, cs_a}, 32'd1);
        check("t4 sclk async", {31'd0, sclk_a}, 32'd0);
        check("t4 data cleared", {24'd0, data_a}, 32'h00);
        call_a = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (1400) @(negedge clk);
        check("t4 no done", done_cnt_a - d0, 32'd0);
        adc_a = 8'h96;
        @(posedge clk); #1 call_a = 2'b01;
        wait_done(1'b0, "t4b", 3000);
        check("t4 next data", {24'd0, data_a}, 32'h96);
        check("t4 next cmd", {24'd0, rx_cmd_a}, 32'hD8);
        call_a = 2'b00;
        repeat (4) @(negedge clk);

        // ---- 5: call held through RELEASE ----
        d0 = done_cnt_a; f0 = cs_fall_cnt_a;
        adc_a = 8'h0F;
        @(posedge clk); #1 call_a = 2'b10;
        wait_done(1'b0, "t5", 3000);
        @(negedge clk);
        call_a = 2'b00;
        repeat (1400) @(negedge clk);
        check("t5 done count", done_cnt_a - d0, 32'd1);
        check("t5 frame count", cs_fall_cnt_a - f0, 32'd1);
        check("t5 data", {24'd0, data_a}, 32'h0F);

        // ---- 6: CLK_DIV = 2 ----
        adc_b = 8'hFF;
        @(posedge clk); #1 call_b = 2'b10; t0 = cyc;
        wait_done(1'b1, "t6a", 300);
        check("t6a latency", cyc - t0, 32'd101);
        check("t6a data", {24'd0, data_b}, 32'hFF);
        check("t6a cmd", {24'd0, rx_cmd_b}, 32'h98);
        call_b = 2'b00;
        repeat (4) @(negedge clk);
        adc_b = 8'h00;
        @(posedge clk); #1 call_b = 2'b01; t0 = cyc;
        wait_done(1'b1, "t6b", 300);
        check("t6b latency", cyc - t0, 32'd101);
        check("t6b data", {24'd0, data_b}, 32'h00);
        check("t6b cmd", {24'd0, rx_cmd_b}, 32'hD8);
        call_b = 2'b00;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
